// File: rtl/v810_pkg.sv
// rtl/v810_pkg.sv - shared types and constants for the v810 bus target
package v810_pkg;

  // Target FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RDMEM = 3'd1,
    WAIT  = 3'd2,
    READY = 3'd3,
    WRMEM = 3'd4
  } tgt_state_t;

  // Bus status encodings; the target only captures them for debug visibility
  localparam logic [1:0] ST_INT_ACK  = 2'b00;
  localparam logic [1:0] ST_HALT_ACK = 2'b01;
  localparam logic [1:0] ST_DATA     = 2'b10;
  localparam logic [1:0] ST_FETCH    = 2'b11;

  // Address window decode: masked address must equal the window base
  function automatic logic window_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/v810_bus_target_wait.sv
// rtl/v810_bus_target_wait.sv - loadable 4-bit wait-state down-counter
module v810_bus_target_wait (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       last
);

  // Load wins over decrement; the counter saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (ce) begin
      if (load) begin
        count <= load_val;
      end else if (dec && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
    end
  end

  // Final wait cycle is the one where the count is 1 (or already 0)
  assign last = (count <= 4'd1);

endmodule

// File: rtl/v810_bus_target.sv
// rtl/v810_bus_target.sv - v810 external bus slave backed by a synchronous memory port
module v810_bus_target
  import v810_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0500_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFF0_0000,
  parameter int          MEM_AW      = 18,
  parameter int          WAIT_STATES = 1,
  parameter bit          IO_SPACE    = 1'b0,
  parameter bit          BUS16       = 1'b0
) (
  input  logic              RESn,
  input  logic              CLK,
  input  logic              CE,
  input  logic [31:0]       A,
  input  logic [31:0]       D_I,
  output logic [31:0]       D_O,
  output logic              D_OE,
  input  logic [3:0]        BEn,
  input  logic [1:0]        ST,
  input  logic              DAn,
  input  logic              MRQn,
  input  logic              RW,
  input  logic              BCYSTn,
  output logic              READYn,
  output logic              SZRQn,
  output logic [MEM_AW-1:0] MEM_A,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_WD,
  input  logic [31:0]       MEM_RD
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  tgt_state_t state, state_next;

  logic       hit;
  logic       start;
  logic       complete;
  logic       cap_rw;
  logic [3:0] cap_be;
  logic [1:0] cap_st;
  logic [3:0] wait_count;
  logic       wait_last;

  // A new cycle is only accepted while idle or while the previous write drains
  assign hit      = window_hit(A, ADDR_BASE, ADDR_MASK) && (MRQn == IO_SPACE);
  assign start    = !BCYSTn && hit && ((state == IDLE) || (state == WRMEM));
  assign complete = (state == READY) && !DAn;

  v810_bus_target_wait u_wait (
    .clk      (CLK),
    .rst_n    (RESn),
    .ce       (CE),
    .load     (start),
    .load_val (WS),
    .dec      (state == WAIT),
    .count    (wait_count),
    .last     (wait_last)
  );

  // State register, advancing only on enabled cycles
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state <= IDLE;
    end else if (CE) begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WRMEM: begin
        if (start) begin
          if (RW) begin
            state_next = RDMEM;
          end else if (WS == 4'd0) begin
            state_next = READY;
          end else begin
            state_next = WAIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RDMEM:   state_next = (wait_count == 4'd0) ? READY : WAIT;
      WAIT:    if (wait_last) state_next = READY;
      READY:   if (!DAn) state_next = cap_rw ? IDLE : WRMEM;
      default: state_next = IDLE;
    endcase
  end

  // Bus handshake; READYn is withheld while DAn is high so the CPU sees no early ready
  assign READYn = !complete;
  assign SZRQn  = !(complete && BUS16);
  assign D_OE   = (state == READY) && cap_rw;

  // Cycle capture, memory strobes and read/write data registers
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      D_O    <= 32'd0;
      MEM_A  <= '0;
      MEM_RE <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_BE <= 4'd0;
      MEM_WD <= 32'd0;
      cap_rw <= 1'b0;
      cap_be <= 4'd0;
      cap_st <= 2'd0;
    end else if (CE) begin
      MEM_RE <= 1'b0;
      MEM_WE <= 1'b0;
      if (start) begin
        MEM_A  <= A[MEM_AW+1:2];
        MEM_RE <= RW;
        cap_rw <= RW;
        cap_be <= ~BEn;
        cap_st <= ST;
      end
      if (state == RDMEM) begin
        D_O <= MEM_RD;
      end
      if (complete && !cap_rw) begin
        MEM_WD <= D_I;
        MEM_BE <= cap_be;
        MEM_WE <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_v810_bus_target.sv
// tb/tb_v810_bus_target.sv - scoreboard bench with three targets sharing one bus
`timescale 1ns/1ps
module tb_v810_bus_target;

  localparam int NI = 3;
  localparam int AW = 8;
  localparam int MW = 2 ** AW;
  localparam logic [31:0] BASE [NI] = '{32'h0500_0000, 32'h0600_0000, 32'h0800_0000};
  localparam int WS_P [NI] = '{1, 0, 3};
  localparam bit IO_P [NI] = '{1'b0, 1'b0, 1'b1};
  localparam bit B16_P [NI] = '{1'b0, 1'b1, 1'b0};

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] D_I = 32'd0;
  logic [3:0]  BEn = 4'hF;
  logic [1:0]  ST = 2'd0;
  logic        DAn = 1'b0;
  logic        MRQn = 1'b0;
  logic        RW = 1'b1;
  logic        BCYSTn = 1'b1;

  logic [31:0]   d_o    [NI];
  logic          d_oe   [NI];
  logic          readyn [NI];
  logic          szrqn  [NI];
  logic [AW-1:0] mem_a  [NI];
  logic          mem_re [NI];
  logic          mem_we [NI];
  logic [3:0]    mem_be [NI];
  logic [31:0]   mem_wd [NI];
  logic [31:0]   mem_rd [NI];

  logic [31:0] phys    [NI][MW];
  logic [31:0] ref_mem [NI][MW];

  typedef struct { int inst; bit rd; logic [31:0] data; int ce; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [3:0] be; logic [31:0] wd; } wr_t;
  typedef struct { logic [AW-1:0] addr; int ce; } re_t;

  rsp_t rsp_q [$];
  wr_t  wr_q  [NI][$];
  re_t  re_q  [NI][$];

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int done_cnt = 0;
  int ce_mode = 0;

  for (genvar g = 0; g < NI; g++) begin : g_tgt
    v810_bus_target #(
      .ADDR_BASE   (BASE[g]),
      .MEM_AW      (AW),
      .WAIT_STATES (WS_P[g]),
      .IO_SPACE    (IO_P[g]),
      .BUS16       (B16_P[g])
    ) u_dut (
      .RESn   (RESn),
      .CLK    (CLK),
      .CE     (CE),
      .A      (A),
      .D_I    (D_I),
      .D_O    (d_o[g]),
      .D_OE   (d_oe[g]),
      .BEn    (BEn),
      .ST     (ST),
      .DAn    (DAn),
      .MRQn   (MRQn),
      .RW     (RW),
      .BCYSTn (BCYSTn),
      .READYn (readyn[g]),
      .SZRQn  (szrqn[g]),
      .MEM_A  (mem_a[g]),
      .MEM_RE (mem_re[g]),
      .MEM_WE (mem_we[g]),
      .MEM_BE (mem_be[g]),
      .MEM_WD (mem_wd[g]),
      .MEM_RD (mem_rd[g])
    );
    assign mem_rd[g] = phys[g][mem_a[g]];
  end

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by the model", name);
  endfunction

  // Clock-enable pattern: steady, alternating, or random
  always @(posedge CLK) begin
    #1;
    case (ce_mode)
      1:       CE = ~CE;
      2:       CE = 1'($urandom_range(0, 1));
      default: CE = 1'b1;
    endcase
  end

  always @(posedge CLK) if (CE) ce_cnt++;

  // Synchronous memory behind each target; strobes qualified with CE here
  always @(posedge CLK) begin
    if (RESn && CE) begin
      for (int i = 0; i < NI; i++) begin
        if (mem_we[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[i][b]) phys[i][mem_a[i]][8*b +: 8] = mem_wd[i][8*b +: 8];
          end
        end
      end
    end
  end

  int           nrdy;
  int           noe;
  rsp_t         r;
  wr_t          w;
  re_t          e;
  logic [78:0]  snap [NI];
  logic [78:0]  now_s;
  bit           snap_ok = 1'b0;
  bit           prev_ce = 1'b1;

  // Monitor: pops the scoreboard whenever a target presents READYn or a memory strobe
  always @(negedge CLK) begin
    if (!RESn) begin
      snap_ok = 1'b0;
    end else begin
      nrdy = 0;
      noe  = 0;
      for (int i = 0; i < NI; i++) begin
        if (!readyn[i]) nrdy++;
        if (d_oe[i]) noe++;
        if (readyn[i]) chk("szrqn_idle", 64'(szrqn[i]), 64'd1);
        now_s = {d_o[i], mem_a[i], mem_re[i], mem_we[i], mem_be[i], mem_wd[i], d_oe[i]};
        if (snap_ok && !prev_ce) chk("hold_on_ce0", 64'(now_s != snap[i]), 64'd0);
        snap[i] = now_s;
        if (CE && mem_we[i]) begin
          if (wr_q[i].size() == 0) fail_now("unexpected_mem_we");
          else begin
            w = wr_q[i].pop_front();
            chk("mem_we_addr", 64'(mem_a[i]), 64'(w.addr));
            chk("mem_we_be", 64'(mem_be[i]), 64'(w.be));
            chk("mem_we_wd", 64'(mem_wd[i]), 64'(w.wd));
          end
        end
        if (CE && mem_re[i]) begin
          if (re_q[i].size() == 0) fail_now("unexpected_mem_re");
          else begin
            e = re_q[i].pop_front();
            chk("mem_re_addr", 64'(mem_a[i]), 64'(e.addr));
            chk("mem_re_cycle", 64'(ce_cnt), 64'(e.ce));
          end
        end
      end
      if (nrdy > 1 || noe > 1) fail_now("bus_contention");
      if (CE) begin
        for (int i = 0; i < NI; i++) begin
          if (!readyn[i]) begin
            if (rsp_q.size() == 0) fail_now("unexpected_readyn");
            else begin
              r = rsp_q.pop_front();
              chk("rsp_target", 64'(i), 64'(r.inst));
              chk("rsp_latency", 64'(ce_cnt), 64'(r.ce));
              chk("rsp_d_oe", 64'(d_oe[i]), 64'(r.rd));
              chk("rsp_szrqn", 64'(szrqn[i]), 64'(!B16_P[i]));
              if (r.rd) chk("rsp_rdata", 64'(d_o[i]), 64'(r.data));
              done_cnt++;
            end
          end
        end
      end
      prev_ce = CE;
      snap_ok = 1'b1;
    end
  end

  // One complete bus cycle from T1 through READYn; expectations come from the access rules
  task automatic bus_cycle(input int inst, input bit rd, input logic [AW-1:0] waddr,
                           input logic [3:0] ben, input logic [31:0] wdata, input int hold);
    int c1;
    int lat;
    int start_done;
    bit ce_now;
    bit accepted;
    bit done;
    rsp_t rs;
    wr_t  ws;
    re_t  es;
    A      = BASE[inst] + {22'd0, waddr, 2'b00};
    RW     = rd;
    BEn    = ben;
    D_I    = wdata;
    MRQn   = IO_P[inst];
    ST     = 2'($urandom);
    DAn    = (hold > 0);
    BCYSTn = 1'b0;
    accepted = 1'b0;
    c1 = 0;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge CLK);
      c1 = ce_cnt;
      ce_now = CE;
      @(posedge CLK);
      accepted = ce_now;
    end
    #1;
    BCYSTn = 1'b1;
    if (!accepted) begin
      fail_now("t1_not_accepted");
      DAn = 1'b0;
      return;
    end
    lat = (rd ? 2 : 1) + WS_P[inst];
    rs.inst = inst;
    rs.rd   = rd;
    rs.data = rd ? ref_mem[inst][waddr] : 32'd0;
    rs.ce   = c1 + lat + hold;
    start_done = done_cnt;
    rsp_q.push_back(rs);
    if (rd) begin
      es.addr = waddr;
      es.ce   = c1 + 1;
      re_q[inst].push_back(es);
    end else begin
      ws.addr = waddr;
      ws.be   = ~ben;
      ws.wd   = wdata;
      wr_q[inst].push_back(ws);
      for (int b = 0; b < 4; b++) begin
        if (!ben[b]) ref_mem[inst][waddr][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (hold > 0 && ce_cnt >= c1 + lat + hold) DAn = 1'b0;
      if (done_cnt != start_done) done = 1'b1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    if (!done) begin
      fail_now("response_timeout");
      rsp_q.delete();
    end
    DAn = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < MW; j++) begin
        phys[i][j]    = $urandom;
        ref_mem[i][j] = phys[i][j];
      end
    end
    phys[0][4]    = 32'hDEAD_BEEF;
    ref_mem[0][4] = 32'hDEAD_BEEF;

    #23;
    for (int i = 0; i < NI; i++) begin
      chk("rst_readyn", 64'(readyn[i]), 64'd1);
      chk("rst_szrqn", 64'(szrqn[i]), 64'd1);
      chk("rst_d_oe", 64'(d_oe[i]), 64'd0);
      chk("rst_d_o", 64'(d_o[i]), 64'd0);
      chk("rst_mem_strobes", 64'({mem_re[i], mem_we[i]}), 64'd0);
      chk("rst_mem_regs", 64'({mem_a[i], mem_be[i]}), 64'd0);
      chk("rst_mem_wd", 64'(mem_wd[i]), 64'd0);
    end
    @(posedge CLK);
    #1 RESn = 1'b1;
    idle_cycles(2);

    bus_cycle(0, 1'b1, 8'd4, 4'b0000, 32'd0, 0);
    bus_cycle(1, 1'b0, 8'd1, 4'b1100, 32'h1234_5678, 0);
    bus_cycle(1, 1'b1, 8'd1, 4'b0000, 32'd0, 0);

    for (int p = 0; p < 2; p++) begin
      A      = (p == 0) ? 32'h0700_0000 : BASE[0];
      MRQn   = (p == 0) ? 1'b0 : 1'b1;
      RW     = p[0];
      BCYSTn = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge CLK);
        for (int i = 0; i < NI; i++) begin
          chk("miss_quiet", 64'({readyn[i], szrqn[i], d_oe[i], mem_re[i], mem_we[i]}), 64'b11000);
        end
        @(posedge CLK);
        #1;
      end
      BCYSTn = 1'b1;
    end
    MRQn = 1'b0;

    bus_cycle(1, 1'b1, 8'd7, 4'b0000, 32'd0, 3);

    ce_mode = 1;
    bus_cycle(2, 1'b1, 8'd9, 4'b0000, 32'd0, 0);
    bus_cycle(2, 1'b0, 8'd9, 4'b0101, 32'hA5A5_5A5A, 0);
    ce_mode = 0;
    idle_cycles(3);

    A      = BASE[0] + 32'd32;
    RW     = 1'b0;
    BEn    = 4'b0000;
    D_I    = 32'hCAFE_F00D;
    MRQn   = 1'b0;
    BCYSTn = 1'b0;
    @(posedge CLK);
    #1 BCYSTn = 1'b1;
    @(negedge CLK);
    #2 RESn = 1'b0;
    #1;
    chk("midrst_readyn", 64'(readyn[0]), 64'd1);
    chk("midrst_mem_we", 64'(mem_we[0]), 64'd0);
    chk("midrst_d_o", 64'(d_o[0]), 64'd0);
    chk("midrst_mem_a", 64'(mem_a[0]), 64'd0);
    idle_cycles(2);
    @(negedge CLK);
    #2 RESn = 1'b1;
    idle_cycles(8);
    bus_cycle(0, 1'b1, 8'd8, 4'b0000, 32'd0, 0);

    for (int t = 0; t < 60; t++) begin
      ce_mode = (t >= 30) ? 2 : 0;
      bus_cycle($urandom_range(0, NI - 1), 1'($urandom), 8'($urandom), 4'($urandom),
                $urandom, (($urandom % 4) == 0) ? $urandom_range(1, 2) : 0);
      if (($urandom % 3) == 0) idle_cycles($urandom_range(0, 2));
    end
    ce_mode = 0;
    for (int i = 0; i < NI; i++) begin
      bus_cycle(i, 1'b1, 8'd1, 4'b0000, 32'd0, 0);
      bus_cycle(i, 1'b1, 8'd9, 4'b0000, 32'd0, 0);
    end
    idle_cycles(6);

    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    for (int i = 0; i < NI; i++) begin
      chk("wr_q_drained", 64'(wr_q[i].size()), 64'd0);
      chk("re_q_drained", 64'(re_q[i].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
